alu_writeback_seq: RTL and testbench

//  Multi-cycle execute/write-back sequencer that drives the 32x32 register file.

---
 rtl/alu_wb_pkg.sv | 23 ++
 rtl/alu_core.sv | 34 +++
 rtl/alu_writeback_seq.sv | 110 +++++++++++
 tb/tb_alu_writeback_seq.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_wb_pkg.sv
// Shared encodings for the ALU execute/write-back sequencer.
// Holds the opcode and FSM state enumerations used by the top level and the ALU core.
package alu_wb_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_XOR  = 3'b100,
        OP_SLT  = 3'b101,
        OP_SLL  = 3'b110,
        OP_ADDI = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_EXEC  = 2'd2,
        S_WRITE = 2'd3
    } state_e;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU: (op, a, b, imm) -> y.
// The 16-bit immediate is sign-extended and used only by ADDI, which ignores b.
module alu_core
    import alu_wb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  op_e               op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [15:0]       imm,
    output logic [DATA_W-1:0] y
);

    logic [DATA_W-1:0] imm_ext;

    assign imm_ext = {{(DATA_W-16){imm[15]}}, imm};

    // NOTE: y gets a default before the case so no path can infer a latch.
    always_comb begin
        y = '0;
        unique case (op)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_SLT:  y = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLL:  y = a << b[4:0];
            OP_ADDI: y = a + imm_ext;
        endcase
    end

endmodule

// File: rtl/alu_writeback_seq.sv
// Four-state execute/write-back sequencer driving a 32x32 register file.
// IDLE accepts, READ captures operands, EXEC computes, WRITE drives one registered write.
module alu_writeback_seq
    import alu_wb_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int CNT_W   = 16,
    parameter int ZERO_RO = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [2:0]        op,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    input  logic [ADDR_W-1:0] rd,
    input  logic [15:0]       imm,
    output logic [ADDR_W-1:0] rf_rs,
    output logic [ADDR_W-1:0] rf_rt,
    input  logic [DATA_W-1:0] rf_reg_s,
    input  logic [DATA_W-1:0] rf_reg_t,
    output logic [ADDR_W-1:0] rf_rd,
    output logic [DATA_W-1:0] rf_write_data,
    output logic              rf_reg_write,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic [CNT_W-1:0]  retired
);

    state_e            state_q, state_d;
    op_e               op_q;
    logic [ADDR_W-1:0] rd_q;
    logic [15:0]       imm_q;
    logic [DATA_W-1:0] op_a, op_b;
    logic [DATA_W-1:0] alu_y;
    logic              wr_en;

    alu_core #(.DATA_W(DATA_W)) u_alu (
        .op  (op_q),
        .a   (op_a),
        .b   (op_b),
        .imm (imm_q),
        .y   (alu_y)
    );

    assign instr_ready = (state_q == S_IDLE);
    assign wr_en       = !((ZERO_RO != 0) && (rd_q == '0));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (instr_valid) state_d = S_READ;
            S_READ:  state_d = S_EXEC;
            S_EXEC:  state_d = S_WRITE;
            S_WRITE: state_d = S_IDLE;
        endcase
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            op_q          <= OP_ADD;
            rd_q          <= '0;
            imm_q         <= '0;
            op_a          <= '0;
            op_b          <= '0;
            rf_rs         <= '0;
            rf_rt         <= '0;
            rf_rd         <= '0;
            rf_write_data <= '0;
            rf_reg_write  <= 1'b0;
            done          <= 1'b0;
            result        <= '0;
            retired       <= '0;
        end else begin
            state_q      <= state_d;
            rf_reg_write <= 1'b0;
            done         <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (instr_valid) begin
                        op_q  <= op_e'(op);
                        rd_q  <= rd;
                        imm_q <= imm;
                        rf_rs <= rs;
                        rf_rt <= rt;
                    end
                end
                S_READ: begin
                    op_a <= rf_reg_s;
                    op_b <= rf_reg_t;
                end
                // Write-back signals are loaded here so they are already stable throughout WRITE.
                S_EXEC: begin
                    result        <= alu_y;
                    rf_write_data <= alu_y;
                    rf_rd         <= rd_q;
                    rf_reg_write  <= wr_en;
                    done          <= 1'b1;
                    retired       <= retired + CNT_W'(1);
                end
                S_WRITE: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_writeback_seq.sv
// Scoreboard bench: a register-file model plus directed instructions with hand-computed results.
// The driver queues expected write-backs; a negedge monitor checks each done pulse against them.
module tb_alu_writeback_seq;
    import alu_wb_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [2:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [4:0]  rf_rs, rf_rt, rf_rd;
    logic [31:0] rf_reg_s, rf_reg_t, rf_write_data, result;
    logic        rf_reg_write, done;
    logic [15:0] retired;

    alu_writeback_seq dut (
        .clk           (clk),
        .reset         (reset),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .op            (op),
        .rs            (rs),
        .rt            (rt),
        .rd            (rd),
        .imm           (imm),
        .rf_rs         (rf_rs),
        .rf_rt         (rf_rt),
        .rf_reg_s      (rf_reg_s),
        .rf_reg_t      (rf_reg_t),
        .rf_rd         (rf_rd),
        .rf_write_data (rf_write_data),
        .rf_reg_write  (rf_reg_write),
        .done          (done),
        .result        (result),
        .retired       (retired)
    );

    always #5 clk = ~clk;

    // Register file model: combinational reads, negedge write.
    logic [31:0] regs [32];
    assign rf_reg_s = regs[rf_rs];
    assign rf_reg_t = regs[rf_rt];
    always @(negedge clk) if (rf_reg_write) regs[rf_rd] <= rf_write_data;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        we;
        logic [15:0] ret;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    int          total  = 0;
    int          passed = 0;
    int          cyc    = 0;
    logic [15:0] exp_retired = '0;
    bit          meas_en = 1'b0;
    int          meas_n = 0, meas_low = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (meas_en && meas_n < 12) begin
            meas_n++;
            if (!instr_ready) meas_low++;
        end
    end

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset) begin
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("wb_latency", 32'(cyc - e.acc), 32'd3);
                    check("rf_reg_write", {31'd0, rf_reg_write}, {31'd0, e.we});
                    check("rf_rd", {27'd0, rf_rd}, {27'd0, e.rd});
                    check("rf_write_data", rf_write_data, e.data);
                    check("result", result, e.data);
                    check("retired", {16'd0, retired}, {16'd0, e.ret});
                end
            end else if (rf_reg_write) begin
                check("stray_write", 32'd1, 32'd0);
            end
        end
    end

    task automatic issue(input op_e o, input logic [4:0] s, input logic [4:0] t,
                         input logic [4:0] d, input logic [15:0] i,
                         input logic [31:0] exp, input bit hold);
        int n = 0;
        exp_t e;
        @(negedge clk);
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!instr_ready) begin
            check("ready_timeout", 32'd0, 32'd1);
            return;
        end
        op = o; rs = s; rt = t; rd = d; imm = i;
        instr_valid = 1'b1;
        exp_retired = exp_retired + 16'd1;
        e.rd = d; e.data = exp; e.we = (d != 5'd0); e.ret = exp_retired; e.acc = cyc;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (!hold) instr_valid = 1'b0;
    endtask

    task automatic release_valid();
        int n = 0;
        @(negedge clk);
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        instr_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        for (int k = 0; k < 32; k++) regs[k] = '0;
        reset = 1'b1; instr_valid = 1'b0;
        op = '0; rs = '0; rt = '0; rd = '0; imm = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, instr_ready}, 32'd1);
        check("rst_rf_rs", {27'd0, rf_rs}, 32'd0);
        check("rst_rf_rd", {27'd0, rf_rd}, 32'd0);
        check("rst_wdata", rf_write_data, 32'd0);
        check("rst_we", {31'd0, rf_reg_write}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_retired", {16'd0, retired}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // 1: first write-back
        issue(OP_ADDI, 5'd0, 5'd0, 5'd1, 16'd5, 32'd5, 1'b0);
        drain();
        check("reg1", regs[1], 32'd5);

        // 2: negative immediate, signed compare, subtract, wrap
        issue(OP_ADDI, 5'd0, 5'd0, 5'd2, 16'hFFFD, 32'hFFFF_FFFD, 1'b0);
        issue(OP_SLT,  5'd2, 5'd1, 5'd3, 16'd0,    32'd1,         1'b0);
        issue(OP_SUB,  5'd1, 5'd2, 5'd4, 16'd0,    32'd8,         1'b0);
        issue(OP_ADDI, 5'd2, 5'd0, 5'd7, 16'd3,    32'd0,         1'b0);
        drain();
        check("reg3", regs[3], 32'd1);
        check("reg7", regs[7], 32'd0);

        // 3: shift and bitwise ops
        issue(OP_SLL, 5'd1, 5'd1, 5'd6, 16'd0, 32'd160, 1'b0);
        issue(OP_XOR, 5'd6, 5'd4, 5'd5, 16'd0, 32'd168, 1'b0);
        issue(OP_AND, 5'd5, 5'd6, 5'd8, 16'd0, 32'd160, 1'b0);
        issue(OP_OR,  5'd1, 5'd4, 5'd9, 16'd0, 32'd13,  1'b0);
        drain();
        check("reg9", regs[9], 32'd13);

        // 4: write to r0 suppressed, still retires
        issue(OP_ADDI, 5'd0, 5'd0, 5'd0, 16'd9, 32'd9, 1'b0);
        drain();
        check("reg0", regs[0], 32'd0);

        // 5: valid held high across three instructions with a RAW chain
        issue(OP_ADDI, 5'd1, 5'd0, 5'd10, 16'd1, 32'd6, 1'b1);
        meas_en = 1'b1;
        issue(OP_ADDI, 5'd10, 5'd0, 5'd10, 16'd1, 32'd7, 1'b1);
        issue(OP_ADD,  5'd10, 5'd1, 5'd12, 16'd0, 32'd12, 1'b1);
        release_valid();
        drain();
        check("ready_low_of_12", 32'(meas_low), 32'd9);
        check("reg10", regs[10], 32'd7);
        check("reg12", regs[12], 32'd12);

        // 6: reset during EXEC drops the write and clears retired
        @(negedge clk);
        op = OP_ADDI; rs = 5'd0; rt = 5'd0; rd = 5'd11; imm = 16'd1;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_ready", {31'd0, instr_ready}, 32'd1);
        check("mid_rst_we", {31'd0, rf_reg_write}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        check("mid_rst_retired", {16'd0, retired}, 32'd0);
        check("mid_rst_result", result, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        exp_retired = '0;
        repeat (6) @(negedge clk);
        check("reg11", regs[11], 32'd0);
        check("post_rst_retired", {16'd0, retired}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
